shader_prog_mem: RTL

// Parametrised shader program memory with a streaming loader and NUM_RD independent read ports.
// A host or boot source streams the program in over a valid/ready interface.

---
 rtl/shader_prog_mem_if.sv | 28 ++
 rtl/shader_prog_mem.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/shader_prog_mem_if.sv
// Loader stream and multi-port fetch bus between a program source/fetch units and shader_prog_mem.
// Latency: none, wires only; the memory registers rd_data/rd_valid one cycle after rd_en.
// Backpressure: ld_ready gates loader beats; read ports are never stalled.
interface shader_prog_mem_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 20,
    parameter int NUM_RD = 2
);
    logic                     ld_start;
    logic                     ld_valid;
    logic [DATA_W-1:0]        ld_data;
    logic                     ld_last;
    logic                     ld_ready;
    logic [NUM_RD-1:0]        rd_en;
    logic [NUM_RD*ADDR_W-1:0] rd_addr;
    logic [NUM_RD*DATA_W-1:0] rd_data;
    logic [NUM_RD-1:0]        rd_valid;

    modport master (
        output ld_start, ld_valid, ld_data, ld_last, rd_en, rd_addr,
        input  ld_ready, rd_data, rd_valid
    );

    modport slave (
        input  ld_start, ld_valid, ld_data, ld_last, rd_en, rd_addr,
        output ld_ready, rd_data, rd_valid
    );
endinterface

// File: rtl/shader_prog_mem.sv
// Shader program memory: streamed loader with zero-fill of the unused tail, NUM_RD read ports.
// Latency: reads return registered data one cycle after rd_en; tail fill takes DEPTH-prog_len cycles.
// Backpressure: ld_ready is high only in LOAD; reads are serviced only while mem_ok is high.
module shader_prog_mem #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 20,
    parameter int NUM_RD = 2
) (
    input  logic              clk,
    input  logic              KEY0,
    shader_prog_mem_if.slave  bus,
    output logic [ADDR_W-1:0] prog_len,
    output logic              busy,
    output logic              mem_ok,
    output logic              ovf_err
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_FILL,
        S_READY
    } state_t;

    state_t             state_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic               ld_ready_q;
    logic               busy_q;
    logic               mem_ok_q;
    logic               ovf_err_q;
    logic [ADDR_W-1:0]  prog_len_q;

    // Program store; deliberately not reset, the fill pass makes the tail deterministic.
    logic [DATA_W-1:0]  mem [DEPTH];

    logic               beat;
    logic               mem_we;
    logic [DATA_W-1:0]  mem_wdata;
    logic [ADDR_W-1:0]  ptr_plus1;

    assign beat      = (state_q == S_LOAD) && ld_ready_q && bus.ld_valid;
    assign ptr_plus1 = ADDR_W'(wr_ptr_q) + ADDR_W'(1);

    // Single write port: loader words during LOAD, zeros during FILL.
    always_comb begin
        mem_we    = 1'b0;
        mem_wdata = '0;
        if (beat) begin
            mem_we    = 1'b1;
            mem_wdata = bus.ld_data;
        end else if (state_q == S_FILL) begin
            mem_we    = 1'b1;
            mem_wdata = '0;
        end
    end

    // Array write at the current write pointer.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    // Load/fill sequencer with registered status outputs.
    always_ff @(posedge clk or negedge KEY0) begin
        if (!KEY0) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            ld_ready_q <= 1'b0;
            busy_q     <= 1'b0;
            mem_ok_q   <= 1'b0;
            ovf_err_q  <= 1'b0;
            prog_len_q <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_READY: begin
                    // Any ld_valid in these states is dropped, ld_ready is low.
                    if (bus.ld_start) begin
                        state_q    <= S_LOAD;
                        wr_ptr_q   <= '0;
                        ld_ready_q <= 1'b1;
                        busy_q     <= 1'b1;
                        mem_ok_q   <= 1'b0;
                        ovf_err_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (beat) begin
                        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                        if (bus.ld_last) begin
                            prog_len_q <= ptr_plus1;
                            ld_ready_q <= 1'b0;
                            if (wr_ptr_q == LAST_PTR) begin
                                // Program fills the whole array, nothing to zero.
                                state_q  <= S_READY;
                                busy_q   <= 1'b0;
                                mem_ok_q <= 1'b1;
                            end else begin
                                state_q <= S_FILL;
                            end
                        end else if (wr_ptr_q == LAST_PTR) begin
                            // Array full without ld_last: truncate and flag it.
                            ovf_err_q  <= 1'b1;
                            prog_len_q <= ADDR_W'(DEPTH);
                            ld_ready_q <= 1'b0;
                            state_q    <= S_READY;
                            busy_q     <= 1'b0;
                            mem_ok_q   <= 1'b1;
                        end
                    end
                end
                S_FILL: begin
                    wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                    if (wr_ptr_q == LAST_PTR) begin
                        state_q  <= S_READY;
                        busy_q   <= 1'b0;
                        mem_ok_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.ld_ready = ld_ready_q;
    assign prog_len     = prog_len_q;
    assign busy         = busy_q;
    assign mem_ok       = mem_ok_q;
    assign ovf_err      = ovf_err_q;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              in_range;
        logic              vld_q;
        logic [DATA_W-1:0] dat_q;

        assign addr     = bus.rd_addr[k*ADDR_W +: ADDR_W];
        assign in_range = (addr < ADDR_W'(DEPTH));

        // Registered read port; out-of-range addresses return zero but still complete.
        always_ff @(posedge clk or negedge KEY0) begin
            if (!KEY0) begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end else if (bus.rd_en[k] && mem_ok_q) begin
                vld_q <= 1'b1;
                dat_q <= in_range ? mem[addr[PTR_W-1:0]] : '0;
            end else begin
                vld_q <= 1'b0;
                dat_q <= '0;
            end
        end

        assign bus.rd_valid[k]                 = vld_q;
        assign bus.rd_data[k*DATA_W +: DATA_W] = dat_q;
    end
endmodule
